command_line_parser: RTL and testbench
======================================

# command_line_parser

Line-oriented command parser between the PS/2 character cleaner and the display/servo consumers. It accumulates cleaned ASCII characters into a 32-character line buffer and handles backspace. On Enter it parses one command (`V<n>` velocity, `A<n>` angle, `F` fire) and publishes registered `velocity`/`angle` words, a one-cycle `fire` pulse, and the completed line (`line_content`, `line_ready`) for the text display.

## Interface
- `MAX_CHARS`, 32: line buffer depth in characters; `line_content` width is 8*MAX_CHARS.
- `VEL_MAX`, 100: velocity clamp value.
- `ANGLE_MAX`, 180: angle clamp value, in degrees.
- `ANGLE_RESET`, 90: angle value after reset.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `input_character`  in  8  cleaned ASCII character.
- `input_made`  in  1  one-cycle strobe; `input_character` is valid while it is high.
- `velocity`  out  32  last accepted velocity, zero-extended.
- `angle`  out  32  last accepted angle, zero-extended.
- `fire`  out  1  one-cycle pulse per accepted `F` command.
- `line_content`  out  256  last completed line; char i at bits [8i+7:8i]; unused bytes are 0x20.
- `line_ready`  out  1  one-cycle pulse when `line_content` updates.
- `cmd_error`  out  1  one-cycle pulse, coincident with `line_ready`, when the line is rejected.
- `busy`  out  1  high in PARSE and COMMIT; strobes arriving while high are dropped.

## Operation
- Reset values:
  - `velocity` = 0, `angle` = ANGLE_RESET.
  - `fire`, `line_ready`, `cmd_error`, `busy` = 0.
  - `line_content` = all 0x20.
  - Buffer empty, length 0, overflow flag clear, state COLLECT.
- FSM states: COLLECT → PARSE → COMMIT → COLLECT.
- COLLECT, on `input_made`:
  - 0x08 (backspace): length decrements, floor 0. The removed slot is rewritten to 0x20. Overflow flag clears.
  - 0x0D (Enter), length 0: ignored, no pulses.
  - 0x0D (Enter), length > 0: go to PARSE with index = 0.
  - Any other byte, length < MAX_CHARS: stored at [length], length increments.
  - Any other byte, buffer full: byte dropped, overflow flag set.
- PARSE: one buffered character per cycle, index 0 .. length-1.
  - Index 0 must be V/v, A/a or F/f; anything else sets the error flag.
  - Index ≥ 1 must be 0x30–0x39 and requires command V or A. Otherwise the error flag is set.
  - Accumulator: acc = min(acc*10 + digit, 16'hFFFF), 16-bit, saturating.
  - V or A with no digits is an error.
  - A set overflow flag is an error.
  - After the last character, go to COMMIT.
- COMMIT, one cycle:
  - `line_content` ← buffer; `line_ready` pulses.
  - On error: `cmd_error` pulses; `velocity` and `angle` are unchanged.
  - Otherwise, V: `velocity` ← min(acc, VEL_MAX).
  - Otherwise, A: `angle` ← min(acc, ANGLE_MAX).
  - Otherwise, F: `fire` pulses.
  - Buffer refilled with 0x20, length, accumulator and flags cleared, go to COLLECT.
- `reset` in any state restores every reset value on the next edge. No partial line is published.

## Timing
- Enter sampled at edge E with length L:
  - PARSE occupies edges E+1 .. E+L.
  - COMMIT registers update at edge E+L+1.
  - `line_ready`, `fire`, `cmd_error` are high for exactly the cycle after E+L+1.
  - `velocity`, `angle` and `line_content` change at that same edge.
- `busy` is high from edge E through edge E+L+1. Characters whose strobe falls in that window are lost; upstream does not retry.
- Back-to-back strobes on consecutive cycles in COLLECT are all accepted.
- Outputs hold between commits.

## Structure
- Shared package `cmd_pkg` holds:
  - ASCII constants: BS = 0x08, CR = 0x0D, SPACE = 0x20, '0', 'V', 'A', 'F' and their lowercase forms.
  - FSM state encoding.
  - Command enum: NONE / VEL / ANG / FIRE.
- One sub-module, `line_buffer`: MAX_CHARS×8 register array.
  - Ports: write, backspace, clear, length, indexed read.
  - Flattened 256-bit view.
- Parser FSM and clamp logic live in the top.

## Test plan
- Type "V45", Enter → `velocity` = 45 at E+4, one `line_ready` pulse, `line_content`[23:0] = "54V" byte order, upper bytes 0x20.
- "a200", Enter → `angle` = 180 (clamped), no `cmd_error`; "A7", Enter → `angle` = 7.
- "F", Enter → single `fire` pulse at E+2; `velocity`/`angle` unchanged.
- "V1X", Enter → `cmd_error` and `line_ready` coincident, `velocity` keeps prior value; "V", Enter → error; 33 × "1" then Enter → error.
- "V12", BS, "9", Enter → `velocity` = 19; BS on empty buffer → no change; a strobe during `busy` is dropped and absent from the next line.
- `reset` asserted mid-PARSE of "A90" → `angle` = ANGLE_RESET, no `line_ready`, next line "V5" parses normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared constants, FSM states and command encoding for the command line parser.
// Pure declarations: no logic, no latency, no flow control.
package cmd_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_V_LC  = 8'h76;
  localparam logic [7:0] CH_A_LC  = 8'h61;
  localparam logic [7:0] CH_F_LC  = 8'h66;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PARSE,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_VEL,
    CMD_ANG,
    CMD_FIRE
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] c);
    case (c)
      CH_V, CH_V_LC: return CMD_VEL;
      CH_A, CH_A_LC: return CMD_ANG;
      CH_F, CH_F_LC: return CMD_FIRE;
      default:       return CMD_NONE;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/command_line_parser_if.sv
// Character strobe in, parsed command words and completed line out.
// Strobe-only input with no ready; busy tells upstream that strobes are being dropped.
interface command_line_parser_if #(
  parameter int MAX_CHARS = 32
);
  logic [7:0]             input_character;
  logic                   input_made;
  logic [31:0]            velocity;
  logic [31:0]            angle;
  logic                   fire;
  logic [8*MAX_CHARS-1:0] line_content;
  logic                   line_ready;
  logic                   cmd_error;
  logic                   busy;

  modport master (
    output input_character, input_made,
    input  velocity, angle, fire, line_content, line_ready, cmd_error, busy
  );

  modport slave (
    input  input_character, input_made,
    output velocity, angle, fire, line_content, line_ready, cmd_error, busy
  );
endinterface

// File: rtl/line_buffer.sv
// Character line store with append, backspace, clear and indexed read; updates on the next edge.
// No backpressure: appends to a full buffer and backspaces on an empty one are ignored.
module line_buffer
  import cmd_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int LW        = $clog2(MAX_CHARS + 1),
  parameter int IW        = $clog2(MAX_CHARS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_dat,
  input  logic                   bs_en,
  input  logic                   clear,
  output logic [LW-1:0]          length,
  input  logic [IW-1:0]          rd_idx,
  output logic [7:0]             rd_dat,
  output logic [8*MAX_CHARS-1:0] flat
);

  logic [7:0]    mem [MAX_CHARS];
  logic [LW-1:0] len_q;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] bs_ptr;

  assign wr_ptr = IW'(len_q);
  assign bs_ptr = IW'(len_q - LW'(1));

  // Erased slots go back to space so the flattened view never shows stale text.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < MAX_CHARS; i++) mem[i] <= CH_SPACE;
      len_q <= '0;
    end else if (wr_en && (len_q < LW'(MAX_CHARS))) begin
      mem[wr_ptr] <= wr_dat;
      len_q       <= len_q + LW'(1);
    end else if (bs_en && (len_q != '0)) begin
      mem[bs_ptr] <= CH_SPACE;
      len_q       <= len_q - LW'(1);
    end
  end

  assign length = len_q;
  assign rd_dat = mem[rd_idx];

  for (genvar g = 0; g < MAX_CHARS; g++) begin : g_flat
    assign flat[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/command_line_parser.sv
// Line editor and V/A/F command parser; Enter with L chars publishes results L+1 cycles later.
// No backpressure: strobes arriving while busy (PARSE/COMMIT) are silently dropped.
module command_line_parser
  import cmd_pkg::*;
#(
  parameter int MAX_CHARS   = 32,
  parameter int VEL_MAX     = 100,
  parameter int ANGLE_MAX   = 180,
  parameter int ANGLE_RESET = 90
) (
  input logic                   clock,
  input logic                   reset,
  command_line_parser_if.slave  bus
);

  localparam int LW = $clog2(MAX_CHARS + 1);
  localparam int IW = $clog2(MAX_CHARS);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [15:0]            acc_q, acc_d;
  cmd_t                   cmd_q, cmd_d;
  logic                   err_q, err_d;
  logic                   dig_q, dig_d;
  logic                   ovf_q, ovf_d;
  logic [31:0]            vel_q, vel_d;
  logic [31:0]            ang_q, ang_d;
  logic                   fire_q, fire_d;
  logic                   lr_q, lr_d;
  logic                   ce_q, ce_d;
  logic [8*MAX_CHARS-1:0] lc_q, lc_d;

  logic                   buf_wr;
  logic                   buf_bs;
  logic                   buf_clr;
  logic [LW-1:0]          buf_len;
  logic [7:0]             buf_rd;
  logic [8*MAX_CHARS-1:0] buf_flat;
  logic [19:0]            acc_ext;
  logic [15:0]            acc_sat;
  logic                   last_idx;
  logic                   line_bad;

  line_buffer #(.MAX_CHARS(MAX_CHARS)) u_line_buffer (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (buf_wr),
    .wr_dat (bus.input_character),
    .bs_en  (buf_bs),
    .clear  (buf_clr),
    .length (buf_len),
    .rd_idx (idx_q),
    .rd_dat (buf_rd),
    .flat   (buf_flat)
  );

  // Digit value is the low nibble of '0'..'9'; the accumulator sticks at 0xFFFF.
  assign acc_ext  = (20'(acc_q) * 20'd10) + {16'd0, buf_rd[3:0]};
  assign acc_sat  = (acc_ext > 20'h0FFFF) ? 16'hFFFF : acc_ext[15:0];
  assign last_idx = (LW'(idx_q) == (buf_len - LW'(1)));
  assign line_bad = err_q | ovf_q | (((cmd_q == CMD_VEL) || (cmd_q == CMD_ANG)) && !dig_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    vel_d   = vel_q;
    ang_d   = ang_q;
    fire_d  = 1'b0;
    lr_d    = 1'b0;
    ce_d    = 1'b0;
    lc_d    = lc_q;
    buf_wr  = 1'b0;
    buf_bs  = 1'b0;
    buf_clr = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (bus.input_made) begin
          if (bus.input_character == CH_BS) begin
            buf_bs = 1'b1;
            ovf_d  = 1'b0;
          end else if (bus.input_character == CH_CR) begin
            if (buf_len != '0) begin
              state_d = ST_PARSE;
              idx_d   = '0;
            end
          end else if (buf_len < LW'(MAX_CHARS)) begin
            buf_wr = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_PARSE: begin
        if (idx_q == '0) begin
          cmd_d = decode_cmd(buf_rd);
          if (decode_cmd(buf_rd) == CMD_NONE) err_d = 1'b1;
        end else if (is_digit(buf_rd) && ((cmd_q == CMD_VEL) || (cmd_q == CMD_ANG))) begin
          acc_d = acc_sat;
          dig_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        if (last_idx) state_d = ST_COMMIT;
        else          idx_d   = idx_q + IW'(1);
      end

      ST_COMMIT: begin
        lc_d = buf_flat;
        lr_d = 1'b1;
        if (line_bad) begin
          ce_d = 1'b1;
        end else begin
          case (cmd_q)
            CMD_VEL:  vel_d  = (32'(acc_q) > 32'(VEL_MAX))   ? 32'(VEL_MAX)   : 32'(acc_q);
            CMD_ANG:  ang_d  = (32'(acc_q) > 32'(ANGLE_MAX)) ? 32'(ANGLE_MAX) : 32'(acc_q);
            CMD_FIRE: fire_d = 1'b1;
            default:  ;
          endcase
        end
        buf_clr = 1'b1;
        idx_d   = '0;
        acc_d   = '0;
        cmd_d   = CMD_NONE;
        err_d   = 1'b0;
        dig_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = ST_COLLECT;
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      acc_q   <= '0;
      cmd_q   <= CMD_NONE;
      err_q   <= 1'b0;
      dig_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vel_q   <= '0;
      ang_q   <= 32'(ANGLE_RESET);
      fire_q  <= 1'b0;
      lr_q    <= 1'b0;
      ce_q    <= 1'b0;
      lc_q    <= {MAX_CHARS{CH_SPACE}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      vel_q   <= vel_d;
      ang_q   <= ang_d;
      fire_q  <= fire_d;
      lr_q    <= lr_d;
      ce_q    <= ce_d;
      lc_q    <= lc_d;
    end
  end

  assign bus.velocity     = vel_q;
  assign bus.angle        = ang_q;
  assign bus.fire         = fire_q;
  assign bus.line_content = lc_q;
  assign bus.line_ready   = lr_q;
  assign bus.cmd_error    = ce_q;
  assign bus.busy         = (state_q != ST_COLLECT);

endmodule

// File: tb/tb_command_line_parser.sv
// Directed and randomized line tests for command_line_parser against a string-level model.
module tb_command_line_parser;

  localparam int MAXC = 32;
  localparam logic [255:0] SPACES = {32{8'h20}};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  command_line_parser_if #(.MAX_CHARS(MAXC)) bus ();

  command_line_parser #(
    .MAX_CHARS(MAXC), .VEL_MAX(100), .ANGLE_MAX(180), .ANGLE_RESET(90)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned stim[$];
  byte unsigned m_buf[$];
  bit           m_ovf = 1'b0;
  int           m_vel = 0;
  int           m_ang = 90;
  byte unsigned inject = 8'h00;

  int           o_lat;
  logic [255:0] o_content;
  logic         o_err, o_fire, o_busy, o_tail_ok;
  logic [31:0]  o_vel, o_ang;

  bit           e_pulse, e_err, e_fire;
  logic [255:0] e_content;
  int           e_lat;

  task automatic load(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic model_push(input byte unsigned c);
    if (c == 8'h08) begin
      if (m_buf.size() > 0) void'(m_buf.pop_back());
      m_ovf = 1'b0;
    end else if (m_buf.size() < MAXC) begin
      m_buf.push_back(c);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Evaluate the pending model line as text, then clear it.
  task automatic model_expect();
    int n, kind, val;
    byte unsigned c;
    n = m_buf.size();
    e_pulse = (n > 0);
    e_lat = n + 1;
    e_err = m_ovf;
    e_fire = 1'b0;
    for (int i = 0; i < MAXC; i++) e_content[8*i +: 8] = (i < n) ? m_buf[i] : 8'h20;
    if (n > 0) begin
      c = m_buf[0];
      kind = (c == 8'h56 || c == 8'h76) ? 1 : (c == 8'h41 || c == 8'h61) ? 2 :
             (c == 8'h46 || c == 8'h66) ? 3 : 0;
      if (kind == 0) e_err = 1'b1;
      if ((kind == 1 || kind == 2) && n == 1) e_err = 1'b1;
      if (kind == 3 && n > 1) e_err = 1'b1;
      val = 0;
      for (int i = 1; i < n; i++) begin
        if (m_buf[i] < 8'h30 || m_buf[i] > 8'h39) e_err = 1'b1;
        else begin
          val = val * 10 + (m_buf[i] - 8'h30);
          if (val > 65535) val = 65535;
        end
      end
      if (!e_err) begin
        if (kind == 1) m_vel = (val > 100) ? 100 : val;
        if (kind == 2) m_ang = (val > 180) ? 180 : val;
        if (kind == 3) e_fire = 1'b1;
      end
    end
    m_buf.delete();
    m_ovf = 1'b0;
  endtask

  task automatic type_stim();
    foreach (stim[i]) begin
      @(negedge clock);
      bus.input_character = stim[i];
      bus.input_made = 1'b1;
      model_push(stim[i]);
    end
  endtask

  // Leaves the bench #1 after the edge that samples Enter.
  task automatic press_enter();
    @(negedge clock);
    bus.input_character = 8'h0D;
    bus.input_made = 1'b1;
    @(posedge clock);
    #1;
    o_busy = bus.busy;
    if (inject != 8'h00) bus.input_character = inject;
    else bus.input_made = 1'b0;
  endtask

  task automatic await_commit();
    o_lat = -1;
    o_tail_ok = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock);
      #1;
      bus.input_made = 1'b0;
      if (bus.line_ready) begin
        o_lat = k;
        o_content = bus.line_content;
        o_err = bus.cmd_error;
        o_fire = bus.fire;
        o_vel = bus.velocity;
        o_ang = bus.angle;
        break;
      end
    end
    if (o_lat > 0) begin
      @(posedge clock);
      #1;
      o_tail_ok = !bus.line_ready && !bus.fire && !bus.cmd_error;
    end
    inject = 8'h00;
  endtask

  task automatic drive_line();
    type_stim();
    press_enter();
    await_commit();
    model_expect();
  endtask

  task automatic test_reset();
    bus.input_made = 1'b0;
    bus.input_character = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (bus.velocity !== 32'd0) begin errors++; $display("FAIL reset_velocity: got %0d want 0", bus.velocity); end
    checks++; if (bus.angle !== 32'd90) begin errors++; $display("FAIL reset_angle: got %0d want 90", bus.angle); end
    checks++; if (bus.line_content !== SPACES) begin errors++; $display("FAIL reset_line: got %h", bus.line_content); end
    checks++; if ({bus.fire, bus.line_ready, bus.cmd_error, bus.busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {bus.fire, bus.line_ready, bus.cmd_error, bus.busy}); end
  endtask

  task automatic test_velocity();
    load("V45");
    drive_line();
    checks++; if (o_lat != 4) begin errors++; $display("FAIL vel_latency: got %0d want 4", o_lat); end
    checks++; if (o_vel !== 32'd45) begin errors++; $display("FAIL vel_value: got %0d want 45", o_vel); end
    checks++; if (o_content[23:0] !== 24'h353456) begin errors++; $display("FAIL vel_line_low: got %h want 353456", o_content[23:0]); end
    checks++; if (o_content[255:24] !== {29{8'h20}}) begin errors++; $display("FAIL vel_line_high: got %h", o_content[255:24]); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL vel_no_error: got %b want 0", o_err); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL vel_busy: got %b want 1", o_busy); end
    checks++; if (o_tail_ok !== 1'b1) begin errors++; $display("FAIL vel_one_pulse: pulses not single-cycle"); end
    repeat (5) @(posedge clock);
    #1;
    checks++; if (bus.velocity !== 32'd45) begin errors++; $display("FAIL vel_hold: got %0d want 45", bus.velocity); end
  endtask

  task automatic test_angle();
    load("a200");
    drive_line();
    checks++; if (o_ang !== 32'd180) begin errors++; $display("FAIL ang_clamp: got %0d want 180", o_ang); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ang_clamp_err: got %b want 0", o_err); end
    checks++; if (o_lat != 5) begin errors++; $display("FAIL ang_latency: got %0d want 5", o_lat); end
    load("A7");
    drive_line();
    checks++; if (o_ang !== 32'd7) begin errors++; $display("FAIL ang_small: got %0d want 7", o_ang); end
    checks++; if (o_vel !== 32'd45) begin errors++; $display("FAIL ang_vel_kept: got %0d want 45", o_vel); end
  endtask

  task automatic test_fire();
    load("F");
    drive_line();
    checks++; if (o_lat != 2) begin errors++; $display("FAIL fire_latency: got %0d want 2", o_lat); end
    checks++; if (o_fire !== 1'b1) begin errors++; $display("FAIL fire_pulse: got %b want 1", o_fire); end
    checks++; if (o_tail_ok !== 1'b1) begin errors++; $display("FAIL fire_one_cycle: fire not single-cycle"); end
    checks++; if ({o_vel, o_ang} !== {32'd45, 32'd7}) begin errors++; $display("FAIL fire_keep: got vel %0d ang %0d want 45 7", o_vel, o_ang); end
  endtask

  task automatic test_errors();
    load("V1X");
    drive_line();
    checks++; if (o_err !== 1'b1 || o_lat != 4) begin errors++; $display("FAIL err_bad_digit: err %b lat %0d want 1 4", o_err, o_lat); end
    checks++; if (o_vel !== 32'd45) begin errors++; $display("FAIL err_vel_kept: got %0d want 45", o_vel); end
    load("V");
    drive_line();
    checks++; if (o_err !== 1'b1 || o_lat != 2) begin errors++; $display("FAIL err_no_digits: err %b lat %0d want 1 2", o_err, o_lat); end
    stim.delete();
    for (int i = 0; i < 33; i++) stim.push_back(8'h31);
    drive_line();
    checks++; if (o_err !== 1'b1 || o_lat != 33) begin errors++; $display("FAIL err_overflow: err %b lat %0d want 1 33", o_err, o_lat); end
    checks++; if (o_content !== {32{8'h31}}) begin errors++; $display("FAIL err_overflow_line: got %h", o_content); end
    load("V");
    for (int i = 0; i < 32; i++) stim.push_back(8'h31);
    drive_line();
    checks++; if (o_err !== 1'b1 || o_vel !== 32'd45) begin errors++; $display("FAIL err_overflow_vel: err %b vel %0d want 1 45", o_err, o_vel); end
  endtask

  task automatic test_backspace();
    load("V12");
    stim.push_back(8'h08);
    stim.push_back(8'h39);
    drive_line();
    checks++; if (o_vel !== 32'd19) begin errors++; $display("FAIL bs_value: got %0d want 19", o_vel); end
    checks++; if (o_content[31:0] !== 32'h20393156) begin errors++; $display("FAIL bs_line: got %h want 20393156", o_content[31:0]); end
    stim.delete();
    stim.push_back(8'h08);
    stim.push_back(8'h08);
    drive_line();
    checks++; if (o_lat != -1 || o_busy !== 1'b0) begin errors++; $display("FAIL bs_empty_enter: lat %0d busy %b want -1 0", o_lat, o_busy); end
    stim.delete();
    stim.push_back(8'h08);
    stim.push_back(8'h08);
    stim.push_back(8'h56);
    stim.push_back(8'h33);
    drive_line();
    checks++; if (o_vel !== 32'd3 || o_lat != 3) begin errors++; $display("FAIL bs_empty_then: vel %0d lat %0d want 3 3", o_vel, o_lat); end
  endtask

  task automatic test_busy_drop();
    load("V6");
    inject = 8'h37;
    drive_line();
    checks++; if (o_vel !== 32'd6) begin errors++; $display("FAIL busy_value: got %0d want 6", o_vel); end
    load("V8");
    drive_line();
    checks++; if (o_vel !== 32'd8 || o_lat != 3) begin errors++; $display("FAIL busy_next: vel %0d lat %0d want 8 3", o_vel, o_lat); end
    checks++; if (o_content !== {SPACES[255:16], 16'h3856}) begin errors++; $display("FAIL busy_dropped: got %h", o_content[31:0]); end
  endtask

  task automatic test_reset_mid_parse();
    bit seen;
    load("A90");
    type_stim();
    press_enter();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_buf.delete();
    m_ovf = 1'b0;
    m_vel = 0;
    m_ang = 90;
    checks++; if (bus.angle !== 32'd90 || bus.velocity !== 32'd0) begin
      errors++; $display("FAIL rst_mid_values: ang %0d vel %0d want 90 0", bus.angle, bus.velocity); end
    checks++; if (bus.line_content !== SPACES || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: busy %b", bus.busy); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      if (bus.line_ready) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_line: got line_ready 1 want 0"); end
    load("V5");
    drive_line();
    checks++; if (o_vel !== 32'd5 || o_lat != 3 || o_ang !== 32'd90) begin
      errors++; $display("FAIL rst_mid_next: vel %0d lat %0d ang %0d want 5 3 90", o_vel, o_lat, o_ang); end
  endtask

  task automatic test_random();
    int n, r;
    for (int it = 0; it < 40; it++) begin
      stim.delete();
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 36) : $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        if (j == 0) begin
          case ($urandom_range(0, 7))
            0: stim.push_back(8'h56);
            1: stim.push_back(8'h76);
            2: stim.push_back(8'h41);
            3: stim.push_back(8'h61);
            4: stim.push_back(8'h46);
            5: stim.push_back(8'h66);
            6: stim.push_back(8'h58);
            default: stim.push_back(8'h35);
          endcase
        end else begin
          r = $urandom_range(0, 99);
          if (r < 8)       stim.push_back(8'h08);
          else if (r < 12) stim.push_back(8'h5A);
          else             stim.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
      end
      drive_line();
      if (e_pulse) begin
        checks++; if (o_lat != e_lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, o_lat, e_lat); end
        checks++; if (o_err !== e_err || o_fire !== e_fire) begin
          errors++; $display("FAIL rnd_flags[%0d]: err %b fire %b want %b %b", it, o_err, o_fire, e_err, e_fire); end
        checks++; if (o_vel !== 32'(m_vel) || o_ang !== 32'(m_ang)) begin
          errors++; $display("FAIL rnd_words[%0d]: vel %0d ang %0d want %0d %0d", it, o_vel, o_ang, m_vel, m_ang); end
        checks++; if (o_content !== e_content) begin errors++; $display("FAIL rnd_line[%0d]: got %h want %h", it, o_content, e_content); end
        checks++; if (o_tail_ok !== 1'b1) begin errors++; $display("FAIL rnd_one_pulse[%0d]: pulses not single-cycle", it); end
      end else begin
        checks++; if (o_lat != -1) begin errors++; $display("FAIL rnd_empty[%0d]: line_ready after %0d want none", it, o_lat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_velocity();
    test_angle();
    test_fire();
    test_errors();
    test_backspace();
    test_busy_drop();
    test_reset_mid_parse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
